xor_fold_stream: RTL and testbench
==================================

Name: xor_fold_stream

Overview:
- Parametrised multi-channel XOR-fold compressor with a valid/ready streaming interface.
- Each channel's IN_W-bit word is folded FOLD ways into an OUT_W = IN_W/FOLD bit word.
- Optional mode accumulates folds across a multi-beat burst into one result.
- Sits between datapath producers and signature/checksum consumers; replaces fixed-width, fixed-channel combinational fold cells with a registered, back-pressurable block.

Parameters:
- IN_W, 16: input word width per channel.
- FOLD, 2: fold factor. IN_W % FOLD != 0 is an elaboration error.
- NCH, 2: number of independent channels.
- CNT_W, 8: width of the beat counter; the counter saturates.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of burst state.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  final beat of burst; used in accumulate mode only.
- in_acc  in  1  mode select, sampled on the first beat of a burst: 1 = accumulate, 0 = pass.
- in_data  in  NCH*IN_W  channel c occupies bits [c*IN_W +: IN_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  NCH*OUT_W  channel c occupies bits [c*OUT_W +: OUT_W].
- out_cnt  out  CNT_W  number of beats folded into out_data, saturating.

Behaviour:
- Fold function: f_c[i] = XOR over k = 0..FOLD-1 of in_data channel c bit (k*OUT_W + i).
- Reset (async, rst_n = 0):
  - out_valid = 0, out_data = 0, out_cnt = 0.
  - FSM goes to IDLE; accumulator = 0; internal count = 0.
  - Applies immediately, mid-burst included; no partial result survives.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - in_ready = !clr && (!out_valid || out_ready). This is a combinational path from out_ready; it is intentional.
  - out_valid, out_data and out_cnt are held stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same cycle.
- FSM states: IDLE, ACC.
- IDLE, beat accepted with in_acc = 0 (pass):
  - Output registers load f with cnt = 1; out_valid = 1 the next cycle (latency 1).
  - in_last is ignored. State stays IDLE.
- IDLE, beat accepted with in_acc = 1:
  - If in_last = 1: output loads f with cnt = 1; state stays IDLE.
  - Otherwise: acc <= f, count <= 1, go to ACC.
- ACC, beat accepted (in_acc ignored):
  - acc <= acc ^ f; count <= sat(count + 1).
  - If in_last = 1: output loads acc ^ f with sat(count + 1); acc <= 0; go to IDLE.
  - out_valid rises the cycle after the last beat is accepted.
- Saturation: count stops at 2^CNT_W - 1; the fold continues.
- clr = 1: acc <= 0, count <= 0, state <= IDLE. No beat is accepted (in_ready = 0). A pending output is unaffected and still drains on out_ready.
- Simultaneous output drain and new result in the same cycle: the new result loads and out_valid stays 1.

Optional Feature:
- Macro XOR_FOLD_PARITY_EN.
- Defined: adds output port out_par (NCH bits). out_par[c] = XOR-reduce of out_data channel c. It is registered with out_data, follows the same hold rules, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Pass mode, defaults: ch0 = 0xA5F0, ch1 = 0x1234, in_acc = 0 -> next cycle out_valid = 1, ch0 = 0x55, ch1 = 0x26, out_cnt = 1.
- Accumulate: in_acc = 1; ch0 beats 0x0102, 0x0304, 0x0508, in_last on the 3rd -> out_valid only after the 3rd beat; ch0 = 0x09, out_cnt = 3.
- Backpressure: out_ready = 0 with a result pending; a second pass beat is offered -> in_ready = 0 and out_data stable. Raise out_ready -> second result appears next cycle; nothing lost or duplicated.
- clr after 2 accumulate beats, then single beat 0x00FF with in_acc = 1, in_last = 1 -> ch0 = 0xFF, out_cnt = 1.
- rst_n pulsed low while out_valid = 1 and mid-burst -> out_valid = 0 and out_cnt = 0 immediately. A fresh pass beat afterwards produces the correct fold.
- CNT_W = 2, 5-beat accumulate burst -> out_cnt = 3 (saturated); data equals the XOR of all 5 folds.

Source files
------------

// File: rtl/xor_fold_stream.sv
// Multi-channel XOR-fold compressor with valid/ready streaming and optional burst accumulation.
// Optional per-channel parity output is enabled with macro XOR_FOLD_PARITY_EN.
module xor_fold_stream #(
   parameter int IN_W  = 16,
   parameter int FOLD  = 2,
   parameter int NCH   = 2,
   parameter int CNT_W = 8,
   localparam int OUT_W = IN_W / FOLD
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic                   in_acc,
   input  logic [NCH*IN_W-1:0]    in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NCH*OUT_W-1:0]   out_data,
   output logic [CNT_W-1:0]       out_cnt
`ifdef XOR_FOLD_PARITY_EN
   ,
   output logic [NCH-1:0]         out_par
`endif
);

   generate
      if (IN_W % FOLD != 0) begin : g_fold_check
         $error("xor_fold_stream: IN_W must be a multiple of FOLD");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. in_ready depends
   // combinationally on out_ready so a drain and a new load share one cycle.
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   accept;
   logic [NCH*OUT_W-1:0]   fold;
   logic [NCH*OUT_W-1:0]   acc;
   logic [NCH*OUT_W-1:0]   acc_fold;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   load_out;
   logic                   load_src_acc;
   logic                   acc_start;
   logic                   acc_step;
   logic                   acc_clear;
   logic [NCH*OUT_W-1:0]   result_data;
   logic [CNT_W-1:0]       result_cnt;

   assign in_ready = !clr && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      fold = '0;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < FOLD; k++) begin
            fold[c*OUT_W +: OUT_W] ^= in_data[c*IN_W + k*OUT_W +: OUT_W];
         end
      end
   end

   assign acc_fold    = acc ^ fold;
   assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   assign result_data = load_src_acc ? acc_fold : fold;
   assign result_cnt  = load_src_acc ? cnt_inc : CNT_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = IDLE;
      end else if (accept) begin
         case (state)
            IDLE:    if (in_acc && !in_last) state_nxt = ACC;
            ACC:     if (in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      load_out     = 1'b0;
      load_src_acc = 1'b0;
      acc_start    = 1'b0;
      acc_step     = 1'b0;
      acc_clear    = 1'b0;
      if (clr) begin
         acc_clear = 1'b1;
      end else if (accept) begin
         case (state)
            IDLE: begin
               if (!in_acc || in_last) load_out = 1'b1;
               else                    acc_start = 1'b1;
            end
            ACC: begin
               if (in_last) begin
                  load_out     = 1'b1;
                  load_src_acc = 1'b1;
                  acc_clear    = 1'b1;
               end else begin
                  acc_step = 1'b1;
               end
            end
            default: acc_clear = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (acc_clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (acc_start) begin
         acc <= fold;
         cnt <= CNT_ONE;
      end else if (acc_step) begin
         acc <= acc_fold;
         cnt <= cnt_inc;
      end
   end

   // load_out implies in_ready, so a stalled result is never overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_data  <= result_data;
         out_cnt   <= result_cnt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef XOR_FOLD_PARITY_EN
   logic [NCH-1:0] result_par;

   always_comb begin
      result_par = '0;
      for (int c = 0; c < NCH; c++) begin
         result_par[c] = ^result_data[c*OUT_W +: OUT_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par <= '0;
      end else if (load_out) begin
         out_par <= result_par;
      end
   end
`endif

endmodule

// File: tb/tb_xor_fold_stream.sv
// Bench for xor_fold_stream: default instance plus a CNT_W=2 instance on shared stimulus,
// checked every cycle against a burst-level model and a set of literal expectations.
module tb_xor_fold_stream;

   localparam int IN_W  = 16;
   localparam int FOLD  = 2;
   localparam int NCH   = 2;
   localparam int OUT_W = IN_W / FOLD;
   localparam int DW    = NCH * IN_W;
   localparam int OW    = NCH * OUT_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr;
   logic          in_valid;
   logic          in_last;
   logic          in_acc;
   logic [DW-1:0] in_data;
   logic          out_ready;
   logic          in_ready,  in_ready2;
   logic          out_valid, out_valid2;
   logic [OW-1:0] out_data,  out_data2;
   logic [7:0]    out_cnt;
   logic [1:0]    out_cnt2;
`ifdef XOR_FOLD_PARITY_EN
   logic [NCH-1:0] out_par, out_par2;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [OW-1:0] exp_q[$];
   int            exp_n_q[$];
   logic          m_burst;
   logic [OW-1:0] m_acc;
   int            m_n;

   always #5 clk = ~clk;

   xor_fold_stream #(.IN_W(IN_W), .FOLD(FOLD), .NCH(NCH), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_acc(in_acc), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
`ifdef XOR_FOLD_PARITY_EN
      , .out_par(out_par)
`endif
   );

   xor_fold_stream #(.IN_W(IN_W), .FOLD(FOLD), .NCH(NCH), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
      .in_last(in_last), .in_acc(in_acc), .in_data(in_data), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .out_cnt(out_cnt2)
`ifdef XOR_FOLD_PARITY_EN
      , .out_par(out_par2)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Each channel: XOR of its OUT_W-bit slices taken by shifting.
   function automatic logic [OW-1:0] model_fold(input logic [DW-1:0] d);
      logic [OW-1:0]    r;
      logic [IN_W-1:0]  w;
      logic [OUT_W-1:0] s;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         w = d[c*IN_W +: IN_W];
         s = '0;
         for (int k = 0; k < FOLD; k++) s ^= OUT_W'(w >> (k*OUT_W));
         r[c*OUT_W +: OUT_W] = s;
      end
      return r;
   endfunction

   function automatic int sat(input int n, input int max);
      return (n > max) ? max : n;
   endfunction

   always @(negedge clk) begin
      logic          exp_valid;
      logic          exp_ready;
      logic [OW-1:0] f;
      if (!rst_n) begin
         exp_q.delete();
         exp_n_q.delete();
         m_burst = 1'b0;
         m_acc   = '0;
         m_n     = 0;
      end else begin
         exp_valid = (exp_q.size() > 0);
         exp_ready = !clr && (!exp_valid || out_ready);
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
         check("out_valid_sat", {31'd0, out_valid2}, {31'd0, exp_valid});
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
         check("in_ready_sat", {31'd0, in_ready2}, {31'd0, exp_ready});
         if (exp_valid) begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            check("out_data_sat", 32'(out_data2), 32'(exp_q[0]));
            check("out_cnt", 32'(out_cnt), sat(exp_n_q[0], 255));
            check("out_cnt_sat", 32'(out_cnt2), sat(exp_n_q[0], 3));
`ifdef XOR_FOLD_PARITY_EN
            for (int c = 0; c < NCH; c++) begin
               check("out_par", {31'd0, out_par[c]}, {31'd0, ^exp_q[0][c*OUT_W +: OUT_W]});
               check("out_par_sat", {31'd0, out_par2[c]}, {31'd0, ^exp_q[0][c*OUT_W +: OUT_W]});
            end
`endif
            if (out_ready) begin
               void'(exp_q.pop_front());
               void'(exp_n_q.pop_front());
            end
         end
         if (clr) begin
            m_burst = 1'b0;
            m_acc   = '0;
            m_n     = 0;
         end else if (in_valid && exp_ready) begin
            f = model_fold(in_data);
            if (!m_burst) begin
               if (!in_acc || in_last) begin
                  exp_q.push_back(f);
                  exp_n_q.push_back(1);
               end else begin
                  m_burst = 1'b1;
                  m_acc   = f;
                  m_n     = 1;
               end
            end else begin
               m_acc ^= f;
               m_n++;
               if (in_last) begin
                  exp_q.push_back(m_acc);
                  exp_n_q.push_back(m_n);
                  m_burst = 1'b0;
                  m_acc   = '0;
                  m_n     = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called and returns at posedge+1; holds the beat until it is taken.
   task automatic send(input logic [DW-1:0] d, input logic a, input logic l);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_acc   = a;
      in_last  = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
            break;
         end
      end
      tick();
      in_valid = 1'b0;
      in_acc   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [OW-1:0] d, input int n8, input int n2);
      @(negedge clk);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_data"}, 32'(out_data), 32'(d));
      check({name, "_cnt"}, 32'(out_cnt), n8);
      check({name, "_cnt_sat"}, 32'(out_cnt2), n2);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_acc = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_cnt", 32'(out_cnt), 32'd0);
      check("rst_cnt_sat", 32'(out_cnt2), 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // pass mode
      send(32'h1234_A5F0, 1'b0, 1'b0);
      expect_out("pass", 16'h2655, 1, 1);

      // three-beat accumulate
      send(32'h0000_0102, 1'b1, 1'b0);
      send(32'h0000_0304, 1'b1, 1'b0);
      @(negedge clk);
      check("acc_early_valid", {31'd0, out_valid}, 32'd0);
      tick();
      send(32'h0000_0508, 1'b1, 1'b1);
      expect_out("acc3", 16'h0009, 3, 3);

      // backpressure
      out_ready = 1'b0;
      send(32'h0000_00FF, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h0000_0F00;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold", 32'(out_data), 32'h0000_00FF);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      expect_out("bp_second", 16'h000F, 1, 1);

      // clear mid-burst, offered beat is refused
      send(32'h0000_0001, 1'b1, 1'b0);
      send(32'h0000_0002, 1'b1, 1'b0);
      clr = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h0000_7777;
      @(negedge clk);
      check("clr_ready", {31'd0, in_ready}, 32'd0);
      tick();
      clr = 1'b0;
      in_valid = 1'b0;
      send(32'h0000_00FF, 1'b1, 1'b1);
      expect_out("after_clr", 16'h00FF, 1, 1);

      // reset with a result pending
      out_ready = 1'b0;
      send(32'h0000_3C00, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_pend_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pend_cnt", 32'(out_cnt), 32'd0);
      check("rst_pend_data", 32'(out_data), 32'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;

      // reset mid-burst
      send(32'h0000_0001, 1'b1, 1'b0);
      send(32'h0000_0002, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("rst_burst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_burst_cnt", 32'(out_cnt), 32'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      send(32'h0000_00F0, 1'b1, 1'b1);
      expect_out("post_rst_single", 16'h00F0, 1, 1);
      send(32'hABCD_1234, 1'b0, 1'b0);
      expect_out("post_rst_pass", 16'h6626, 1, 1);

      // five-beat burst: CNT_W=2 instance saturates at 3
      send(32'h0100_0001, 1'b1, 1'b0);
      send(32'h0100_0002, 1'b1, 1'b0);
      send(32'h0100_0004, 1'b1, 1'b0);
      send(32'h0100_0008, 1'b1, 1'b0);
      send(32'h0100_0010, 1'b1, 1'b1);
      expect_out("sat5", 16'h011F, 5, 3);

      repeat (3) tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
